rs_entry: RTL and testbench
===========================

Name: rs_entry

Overview:
Single reservation-station slot for the out-of-order core. Loads a decoded instruction from dispatch and resolves each source operand from one of three places: the register file (ID packet), the ROB, or a later CDB broadcast. Flags the slot busy while it holds an instruction and ready once both operands are valid, then presents the complete issue packet to issue select logic. A parent RS module instantiates N of these.

Parameters:
None. All widths come from the shared packet typedefs: 32-bit values, and ROB-tag width as defined for MT2RS/CDB/ROB2RS packets. Tag value 0 is reserved and means "no tag".

Ports:
clock  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high reset
id_packet_in  in  ID_PACKET  decoded instruction; rs1_value/rs2_value are register-file operands; valid only when wr_en=1
mt2rs_packet_in  in  MT2RS_PACKET  rs1_tag, rs2_tag (0 = value in register file), rs1_ready, rs2_ready (1 = value already in ROB); valid only when wr_en=1
cdb_packet_in  in  CDB_PACKET  reg_tag (0 = no broadcast), reg_value; sampled every cycle
rob2rs_packet_in  in  ROB2RS_PACKET  rob_entry (destination tag), rs1_value, rs2_value (ROB-held operands); valid only when wr_en=1
clear  in  1  free the slot (instruction issued or squashed)
wr_en  in  1  load a new instruction into the slot
entry_packet  out  IS_PACKET  stored instruction with resolved operand values
busy  out  1  slot occupied
ready  out  1  busy and both operands valid

Behaviour:
- Reset (asynchronous, active-high): busy=0, ready=0, entry_packet all zeros, both operand-valid flags=0, stored tags=0, dest_tag=0.
- All state updates on the rising clock edge. Outputs are driven directly from registers (no combinational input-to-output paths).
- Priority per edge: wr_en > clear > CDB capture.
- Load (wr_en=1), for each operand i in {1,2}:
  - tag_i==0: value = id_packet_in.rsi_value; valid_i=1.
  - tag_i!=0 and rsi_ready=1: value = rob2rs_packet_in.rsi_value; valid_i=1.
  - tag_i!=0 and rsi_ready=0:
    - If cdb reg_tag equals tag_i and is nonzero in the same cycle, value = cdb reg_value and valid_i=1.
    - Otherwise valid_i=0; store tag_i.
  - Other effects of a load:
    - busy becomes 1.
    - All ID_PACKET fields (PC, NPC, inst, selects, dest_reg_idx, alu_func, memory/branch/halt/illegal flags) are copied into entry_packet.
    - entry_packet rs1_value/rs2_value take the resolved values (0 while pending).
    - rob_entry is latched into an internal dest_tag register and held until the slot is reloaded.
  - wr_en while busy overwrites the slot: the new instruction replaces the old one.
  - wr_en together with clear: the load wins and busy stays 1.
- Clear (clear=1, wr_en=0): busy=0, ready=0, valid flags=0. entry_packet contents are don't-care afterwards but held.
- CDB capture: when busy, not loading, and cdb reg_tag!=0, each pending operand whose stored tag equals reg_tag takes reg_value and becomes valid. Both operands may capture in the same cycle. Already-valid operands ignore the CDB.
- ready = busy & valid1 & valid2, registered. It is 1 on the cycle after the last operand resolves, and 1 on the cycle after a load whose operands are both immediately available.
- While not busy, the CDB is ignored.

Test Plan:
- Register-file operands: wr_en=1, tags 0/0, inst=ABCDEF12 → next cycle busy=1, ready=1, entry_packet.inst=ABCDEF12. Hold wr_en=0 → still busy. clear=1 → busy=0.
- ROB operands: tags 1/1, rsX_ready=1, rob_entry=2 → busy=1, ready=1 one cycle after load.
- Both operands waiting on the same tag: tags 1/1, ready=0 → busy=1, ready=0. Then CDB tag 1, value 1 → ready=1, both operands = 1.
- Split resolution: tags 3/4 pending. CDB tag 4 → ready=0. CDB tag 3 → ready=1, with rs1_value and rs2_value both 10. Also: rs1 tag 2 pending, rs2 from ROB, CDB tag 2 value 10 → ready=1.
- Simultaneous clear and wr_en: busy entry, clear=1, wr_en=1 with a new instruction → busy stays 1 and the new instruction is loaded. Then clear=0 → busy=1, ready=1.
- Repeated load and reset: wr_en held two cycles with pending tags → busy=1, ready=0 both cycles. Assert reset mid-operation → busy=0, ready=0 immediately.

Source files
------------

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared packet typedefs for dispatch, map table, ROB, CDB and issue.
package rs_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 5;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [1:0]      opa_select;
    logic [3:0]      opb_select;
    logic [4:0]      dest_reg_idx;
    logic [4:0]      alu_func;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
  } ID_PACKET;

  typedef struct packed {
    rob_tag_t rs1_tag;
    rob_tag_t rs2_tag;
    logic     rs1_ready;
    logic     rs2_ready;
  } MT2RS_PACKET;

  typedef struct packed {
    rob_tag_t        reg_tag;
    logic [XLEN-1:0] reg_value;
  } CDB_PACKET;

  typedef struct packed {
    rob_tag_t        rob_entry;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } ROB2RS_PACKET;

  // Issue packet carries the destination ROB tag so issue/execute can broadcast it.
  typedef struct packed {
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [1:0]      opa_select;
    logic [3:0]      opb_select;
    logic [4:0]      dest_reg_idx;
    logic [4:0]      alu_func;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
    rob_tag_t        dest_tag;
  } IS_PACKET;

endpackage

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - single reservation-station slot resolving operands from RF, ROB or CDB.
module rs_entry
  import rs_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  ID_PACKET     id_packet_in,
  input  MT2RS_PACKET  mt2rs_packet_in,
  input  CDB_PACKET    cdb_packet_in,
  input  ROB2RS_PACKET rob2rs_packet_in,
  input  logic         clear,
  input  logic         wr_en,
  output IS_PACKET     entry_packet,
  output logic         busy,
  output logic         ready
);

  IS_PACKET        entry_q, entry_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            valid1_q, valid1_d;
  logic            valid2_q, valid2_d;
  rob_tag_t        tag1_q, tag1_d;
  rob_tag_t        tag2_q, tag2_d;
  rob_tag_t        dest_tag_q, dest_tag_d;

  logic            cdb_live;
  assign cdb_live = (cdb_packet_in.reg_tag != '0);

  always_comb begin
    entry_d    = entry_q;
    busy_d     = busy_q;
    valid1_d   = valid1_q;
    valid2_d   = valid2_q;
    tag1_d     = tag1_q;
    tag2_d     = tag2_q;
    dest_tag_d = dest_tag_q;

    if (wr_en) begin
      busy_d                 = 1'b1;
      entry_d.NPC            = id_packet_in.NPC;
      entry_d.PC             = id_packet_in.PC;
      entry_d.inst           = id_packet_in.inst;
      entry_d.opa_select     = id_packet_in.opa_select;
      entry_d.opb_select     = id_packet_in.opb_select;
      entry_d.dest_reg_idx   = id_packet_in.dest_reg_idx;
      entry_d.alu_func       = id_packet_in.alu_func;
      entry_d.rd_mem         = id_packet_in.rd_mem;
      entry_d.wr_mem         = id_packet_in.wr_mem;
      entry_d.cond_branch    = id_packet_in.cond_branch;
      entry_d.uncond_branch  = id_packet_in.uncond_branch;
      entry_d.halt           = id_packet_in.halt;
      entry_d.illegal        = id_packet_in.illegal;
      dest_tag_d             = rob2rs_packet_in.rob_entry;
      entry_d.dest_tag       = rob2rs_packet_in.rob_entry;
      tag1_d                 = mt2rs_packet_in.rs1_tag;
      tag2_d                 = mt2rs_packet_in.rs2_tag;

      // Operand 1: RF, then ROB, then a same-cycle CDB bypass, else wait.
      if (mt2rs_packet_in.rs1_tag == '0) begin
        entry_d.rs1_value = id_packet_in.rs1_value;
        valid1_d          = 1'b1;
      end else if (mt2rs_packet_in.rs1_ready) begin
        entry_d.rs1_value = rob2rs_packet_in.rs1_value;
        valid1_d          = 1'b1;
      end else if (cdb_live && cdb_packet_in.reg_tag == mt2rs_packet_in.rs1_tag) begin
        entry_d.rs1_value = cdb_packet_in.reg_value;
        valid1_d          = 1'b1;
      end else begin
        entry_d.rs1_value = '0;
        valid1_d          = 1'b0;
      end

      if (mt2rs_packet_in.rs2_tag == '0) begin
        entry_d.rs2_value = id_packet_in.rs2_value;
        valid2_d          = 1'b1;
      end else if (mt2rs_packet_in.rs2_ready) begin
        entry_d.rs2_value = rob2rs_packet_in.rs2_value;
        valid2_d          = 1'b1;
      end else if (cdb_live && cdb_packet_in.reg_tag == mt2rs_packet_in.rs2_tag) begin
        entry_d.rs2_value = cdb_packet_in.reg_value;
        valid2_d          = 1'b1;
      end else begin
        entry_d.rs2_value = '0;
        valid2_d          = 1'b0;
      end
    end else if (clear) begin
      busy_d   = 1'b0;
      valid1_d = 1'b0;
      valid2_d = 1'b0;
    end else if (busy_q && cdb_live) begin
      if (!valid1_q && tag1_q == cdb_packet_in.reg_tag) begin
        entry_d.rs1_value = cdb_packet_in.reg_value;
        valid1_d          = 1'b1;
      end
      if (!valid2_q && tag2_q == cdb_packet_in.reg_tag) begin
        entry_d.rs2_value = cdb_packet_in.reg_value;
        valid2_d          = 1'b1;
      end
    end

    ready_d = busy_d & valid1_d & valid2_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q    <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      valid1_q   <= 1'b0;
      valid2_q   <= 1'b0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      dest_tag_q <= '0;
    end else begin
      entry_q    <= entry_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      valid1_q   <= valid1_d;
      valid2_q   <= valid2_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      dest_tag_q <= dest_tag_d;
    end
  end

  assign entry_packet = entry_q;
  assign busy         = busy_q;
  assign ready        = ready_q;

endmodule

// File: tb/tb_rs_entry.sv
// tb/tb_rs_entry.sv - table-driven self-checking bench for rs_entry.
module tb_rs_entry;
  import rs_pkg::*;

  logic         clock;
  logic         reset;
  ID_PACKET     id_packet_in;
  MT2RS_PACKET  mt2rs_packet_in;
  CDB_PACKET    cdb_packet_in;
  ROB2RS_PACKET rob2rs_packet_in;
  logic         clear;
  logic         wr_en;
  IS_PACKET     entry_packet;
  logic         busy;
  logic         ready;

  rs_entry dut (
    .clock            (clock),
    .reset            (reset),
    .id_packet_in     (id_packet_in),
    .mt2rs_packet_in  (mt2rs_packet_in),
    .cdb_packet_in    (cdb_packet_in),
    .rob2rs_packet_in (rob2rs_packet_in),
    .clear            (clear),
    .wr_en            (wr_en),
    .entry_packet     (entry_packet),
    .busy             (busy),
    .ready            (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic        clr;
    logic [31:0] inst;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [4:0]  t1;
    logic [4:0]  t2;
    logic        r1;
    logic [31:0] rob1;
    logic        r2;
    logic [31:0] rob2;
    logic [4:0]  dest;
    logic [4:0]  cdbt;
    logic [31:0] cdbv;
    logic        eb;
    logic        er;
    logic        chk;
    logic [31:0] einst;
    logic [31:0] ev1;
    logic [31:0] ev2;
    logic [4:0]  edest;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_packet_in                = '0;
    id_packet_in.inst           = v.inst;
    id_packet_in.PC             = v.inst + 32'h100;
    id_packet_in.NPC            = v.inst + 32'h104;
    id_packet_in.rs1_value      = v.rf1;
    id_packet_in.rs2_value      = v.rf2;
    id_packet_in.alu_func       = v.inst[4:0];
    mt2rs_packet_in.rs1_tag     = v.t1;
    mt2rs_packet_in.rs2_tag     = v.t2;
    mt2rs_packet_in.rs1_ready   = v.r1;
    mt2rs_packet_in.rs2_ready   = v.r2;
    rob2rs_packet_in.rob_entry  = v.dest;
    rob2rs_packet_in.rs1_value  = v.rob1;
    rob2rs_packet_in.rs2_value  = v.rob2;
    cdb_packet_in.reg_tag       = v.cdbt;
    cdb_packet_in.reg_value     = v.cdbv;
    wr_en                       = v.wr;
    clear                       = v.clr;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".busy"},  {31'b0, busy},  {31'b0, v.eb});
    check({tag, ".ready"}, {31'b0, ready}, {31'b0, v.er});
    if (v.chk) begin
      check({tag, ".inst"}, entry_packet.inst, v.einst);
      check({tag, ".pc"},   entry_packet.PC, v.einst + 32'h100);
      check({tag, ".rs1"},  entry_packet.rs1_value, v.ev1);
      check({tag, ".rs2"},  entry_packet.rs2_value, v.ev2);
      check({tag, ".dest"}, {27'b0, entry_packet.dest_tag}, {27'b0, v.edest});
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  vec_t idle;

  initial begin
    //            wr clr inst          rf1 rf2 t1 t2 r1 rob1 r2 rob2 dst cdbt cdbv  eb er chk einst         ev1 ev2 edst
    vecs[0]  = '{1, 0, 32'hABCDEF12, 11, 22, 0, 0, 0, 0,  0, 0,  1,  0, 0,    1, 1, 1, 32'hABCDEF12, 11, 22, 1};
    vecs[1]  = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  0, 0,    1, 1, 1, 32'hABCDEF12, 11, 22, 1};
    vecs[2]  = '{0, 1, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  0, 0,    0, 0, 0, 0,            0,  0,  0};
    vecs[3]  = '{1, 0, 2,            0,  0,  1, 1, 1, 33, 1, 44, 2,  0, 0,    1, 1, 1, 2,            33, 44, 2};
    vecs[4]  = '{1, 0, 3,            55, 66, 1, 1, 0, 0,  0, 0,  3,  0, 0,    1, 0, 1, 3,            0,  0,  3};
    vecs[5]  = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  1, 1,    1, 1, 1, 3,            1,  1,  3};
    vecs[6]  = '{1, 0, 4,            0,  0,  3, 4, 0, 0,  0, 0,  4,  0, 0,    1, 0, 1, 4,            0,  0,  4};
    vecs[7]  = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  4, 10,   1, 0, 1, 4,            0,  10, 4};
    vecs[8]  = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  3, 10,   1, 1, 1, 4,            10, 10, 4};
    vecs[9]  = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  3, 99,   1, 1, 1, 4,            10, 10, 4};
    vecs[10] = '{1, 0, 5,            0,  0,  2, 5, 0, 0,  1, 77, 5,  0, 0,    1, 0, 1, 5,            0,  77, 5};
    vecs[11] = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  2, 10,   1, 1, 1, 5,            10, 77, 5};
    vecs[12] = '{1, 1, 6,            6,  7,  0, 0, 0, 0,  0, 0,  6,  0, 0,    1, 1, 1, 6,            6,  7,  6};
    vecs[13] = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  0, 0,    1, 1, 1, 6,            6,  7,  6};
    vecs[14] = '{0, 1, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  0, 0,    0, 0, 0, 0,            0,  0,  0};
    vecs[15] = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  3, 5,    0, 0, 1, 6,            6,  7,  6};
    vecs[16] = '{1, 0, 7,            0,  0,  6, 7, 0, 0,  0, 0,  7,  6, 88,   1, 0, 1, 7,            88, 0,  7};
    vecs[17] = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  7, 99,   1, 1, 1, 7,            88, 99, 7};
    vecs[18] = '{0, 1, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  7, 1,    0, 0, 0, 0,            0,  0,  0};
    vecs[19] = '{1, 0, 8,            0,  0,  9, 9, 0, 0,  0, 0,  8,  3, 50,   1, 0, 1, 8,            0,  0,  8};
    vecs[20] = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  9, 5,    1, 1, 1, 8,            5,  5,  8};
    idle     = '{0, 0, 0,            0,  0,  0, 0, 0, 0,  0, 0,  0,  0, 0,    0, 0, 0, 0,            0,  0,  0};

    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge clock);
    #1;
    check("reset.busy",  {31'b0, busy},  32'd0);
    check("reset.ready", {31'b0, ready}, 32'd0);
    check("reset.inst",  entry_packet.inst, 32'd0);
    check("reset.dest",  {27'b0, entry_packet.dest_tag}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      @(posedge clock);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // wr_en held two cycles with pending tags, then asynchronous reset mid-cycle.
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      drive('{1, 0, 32'h9 + k, 0, 0, 10, 11, 0, 0, 0, 0, 5'(12 + k), 0, 0,
              1, 0, 1, 32'h9 + k, 0, 0, 5'(12 + k)});
      @(posedge clock);
      #1;
      check($sformatf("hold%0d.busy", k),  {31'b0, busy},  32'd1);
      check($sformatf("hold%0d.ready", k), {31'b0, ready}, 32'd0);
      check($sformatf("hold%0d.inst", k),  entry_packet.inst, 32'h9 + k);
      check($sformatf("hold%0d.dest", k),  {27'b0, entry_packet.dest_tag}, 32'd12 + k);
    end
    @(negedge clock);
    drive(idle);
    #1;
    reset = 1'b1;
    #1;
    check("areset.busy",  {31'b0, busy},  32'd0);
    check("areset.ready", {31'b0, ready}, 32'd0);
    check("areset.inst",  entry_packet.inst, 32'd0);
    check("areset.dest",  {27'b0, entry_packet.dest_tag}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Stale tags from before reset must not let the CDB wake an empty slot.
    @(negedge clock);
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 3, 0, 0, 0, 0, 0, 0, 0});
    @(posedge clock);
    #1;
    check("post_reset_cdb.busy",  {31'b0, busy},  32'd0);
    check("post_reset_cdb.rs1",   entry_packet.rs1_value, 32'd0);

    @(negedge clock);
    drive('{1, 0, 32'h1234, 4, 5, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 1, 32'h1234, 4, 5, 3});
    @(posedge clock);
    #1;
    check("recover.ready", {31'b0, ready}, 32'd1);
    check("recover.rs2",   entry_packet.rs2_value, 32'd5);

    @(negedge clock);
    drive(idle);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
